// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap unit; latches exceptions, external interrupts and mret, owns the trap CSRs, and redirects fetch.
// Latency: event cycle -> e_raised/e_handling_addr registered 1 cycle later; DRAIN lasts DRAIN_CYCLES cycles after the redirect is taken.
// Backpressure: the redirect is held in REDIRECT while jump=1 (the fetch selector favours jump); new events are ignored outside RUN.
//
// Ports:
//   clk, rst_n                       core clock, asynchronous active-low reset
//   exc_valid/exc_code/exc_pc/exc_tval  synchronous exception from the pipeline
//   ext_irq, irq_pc                  level machine external interrupt and its resume PC
//   mret                             mret retiring this cycle
//   jump                             branch/jump redirect competing for the fetch selector
//   csr_we/csr_addr/csr_wdata        CSR write port; csr_rdata is combinational on csr_addr
//   e_raised, e_handling_addr        redirect request and target to fetch
//   flush                            squash IF/ID/EX contents
//   trap_busy                        high whenever the unit is not in RUN
//
// Optional feature macro: MTVEC_VECTORED_EN
//   defined   -> mtvec[1:0]=01 selects vectored mode; interrupts go to base + 4*cause,
//                exceptions to base; mtvec bit 0 is writable.
//   undefined -> mtvec[1:0] forced to 00 on write; all traps go to base.

module trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        ext_irq,
    input  logic [31:0] irq_pc,
    input  logic        mret,
    input  logic        jump,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        e_raised,
    output logic [31:0] e_handling_addr,
    output logic        flush,
    output logic        trap_busy
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [31:0] IRQ_CAUSE     = 32'h8000_000B;
    localparam logic [3:0]  DRAIN_LOAD    = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  drain_cnt_q;
    logic        e_raised_q;
    logic        flush_q;
    logic        trap_busy_q;
    logic [31:0] e_addr_q;

    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic        mst_mie_q,  mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic        meie_q,     meie_d;

    // ------------------------------------------------------------------
    // Event arbitration (RUN only): exception > enabled interrupt > mret
    // ------------------------------------------------------------------
    logic in_run;
    logic irq_pending;
    logic take_exc;
    logic take_irq;
    logic take_mret;
    logic take_trap;

    assign in_run      = (state_q == S_RUN);
    assign irq_pending = ext_irq & mst_mie_q & meie_q;
    assign take_exc    = in_run & exc_valid;
    assign take_irq    = in_run & ~exc_valid & irq_pending;
    assign take_mret   = in_run & ~exc_valid & ~irq_pending & mret;
    assign take_trap   = take_exc | take_irq;

    // ------------------------------------------------------------------
    // Trap target
    // ------------------------------------------------------------------
    logic [31:0] mtvec_base;
    logic [31:0] trap_target;

    assign mtvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        trap_target = mtvec_base;
`ifdef MTVEC_VECTORED_EN
        // Only interrupts are vectored; cause 11 lands at base + 0x2C.
        if (take_irq && (mtvec_q[1:0] == 2'b01)) begin
            trap_target = mtvec_base + 32'h0000_002C;
        end
`endif
    end

    // ------------------------------------------------------------------
    // CSR next-state: software write first, hardware trap/mret update
    // overrides it for the registers the hardware owns that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mscratch_d = mscratch_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        meie_d     = meie_q;

        if (csr_we) begin
            unique case (csr_addr)
                ADDR_MSTATUS: begin
                    mst_mie_d  = csr_wdata[3];
                    mst_mpie_d = csr_wdata[7];
                end
                ADDR_MIE:      meie_d     = csr_wdata[11];
`ifdef MTVEC_VECTORED_EN
                ADDR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 1'b0, csr_wdata[0]};
`else
                ADDR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 2'b00};
`endif
                ADDR_MSCRATCH: mscratch_d = csr_wdata;
                ADDR_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
                ADDR_MCAUSE:   mcause_d   = csr_wdata;
                ADDR_MTVAL:    mtval_d    = csr_wdata;
                default: ;
            endcase
        end

        if (take_exc) begin
            mepc_d     = {exc_pc[31:2], 2'b00};
            mcause_d   = {28'd0, exc_code};
            mtval_d    = exc_tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (take_irq) begin
            mepc_d     = {irq_pc[31:2], 2'b00};
            mcause_d   = IRQ_CAUSE;
            mtval_d    = 32'd0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (take_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mscratch_q <= 32'd0;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            meie_q     <= 1'b0;
        end else begin
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mscratch_q <= mscratch_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            meie_q     <= meie_d;
        end
    end

    // ------------------------------------------------------------------
    // CSR read mux
    // ------------------------------------------------------------------
    always_comb begin
        csr_rdata = 32'd0;
        unique case (csr_addr)
            ADDR_MSTATUS:  csr_rdata = {24'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
            ADDR_MIE:      csr_rdata = {20'd0, meie_q, 11'd0};
            ADDR_MTVEC:    csr_rdata = mtvec_q;
            ADDR_MSCRATCH: csr_rdata = mscratch_q;
            ADDR_MEPC:     csr_rdata = mepc_q;
            ADDR_MCAUSE:   csr_rdata = mcause_q;
            ADDR_MTVAL:    csr_rdata = mtval_q;
            ADDR_MIP:      csr_rdata = {20'd0, ext_irq, 11'd0};
            default:       csr_rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Redirect FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            drain_cnt_q <= 4'd0;
            e_raised_q  <= 1'b0;
            flush_q     <= 1'b0;
            trap_busy_q <= 1'b0;
            e_addr_q    <= 32'd0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (take_trap || take_mret) begin
                        state_q     <= S_REDIRECT;
                        e_raised_q  <= 1'b1;
                        flush_q     <= 1'b1;
                        trap_busy_q <= 1'b1;
                        e_addr_q    <= take_trap ? trap_target : mepc_q;
                    end
                end
                S_REDIRECT: begin
                    // jump wins the fetch selector; keep asserting until a
                    // cycle without it, which is when fetch takes our target.
                    if (!jump) begin
                        state_q     <= S_DRAIN;
                        e_raised_q  <= 1'b0;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == 4'd0) begin
                        state_q     <= S_RUN;
                        flush_q     <= 1'b0;
                        trap_busy_q <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= S_RUN;
                    e_raised_q  <= 1'b0;
                    flush_q     <= 1'b0;
                    trap_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign e_raised        = e_raised_q;
    assign flush           = flush_q;
    assign trap_busy       = trap_busy_q;
    assign e_handling_addr = e_addr_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed, table-driven check of trap_ctrl CSRs plus hand-written trap/mret/jump/drain sequences.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: jump is driven by the bench to hold the redirect; every wait is cycle-bounded.

module tb_trap_ctrl;

`ifdef MTVEC_VECTORED_EN
    localparam logic [31:0] MTVEC_W203 = 32'h0000_0201;
    localparam logic [31:0] IRQ_VEC_TGT = 32'h0000_022C;
    localparam logic [31:0] MTVEC_R201 = 32'h0000_0201;
`else
    localparam logic [31:0] MTVEC_W203 = 32'h0000_0200;
    localparam logic [31:0] IRQ_VEC_TGT = 32'h0000_0200;
    localparam logic [31:0] MTVEC_R201 = 32'h0000_0200;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        ext_irq;
    logic [31:0] irq_pc;
    logic        mret;
    logic        jump;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        e_raised;
    logic [31:0] e_handling_addr;
    logic        flush;
    logic        trap_busy;

    int errors = 0;
    int checks = 0;

    trap_ctrl #(
        .RESET_MTVEC (32'h0000_0100),
        .DRAIN_CYCLES(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .ext_irq        (ext_irq),
        .irq_pc         (irq_pc),
        .mret           (mret),
        .jump           (jump),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .e_raised       (e_raised),
        .e_handling_addr(e_handling_addr),
        .flush          (flush),
        .trap_busy      (trap_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } csr_vec_t;

    csr_vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        csr_addr = addr;
        #1;
        data = csr_rdata;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        exc_valid = 1'b0;
        exc_code  = 4'd0;
        exc_pc    = 32'd0;
        exc_tval  = 32'd0;
        ext_irq   = 1'b0;
        irq_pc    = 32'd0;
        mret      = 1'b0;
        jump      = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = 12'd0;
        csr_wdata = 32'd0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Wait (bounded) until the unit is back in RUN.
    task automatic wait_run(input string name);
        int n = 0;
        while (trap_busy && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (trap_busy) begin
            errors++;
            $display("FAIL %s: trap_busy still 1 after %0d cycles, expected 0", name, n);
        end
    endtask

    initial begin
        logic [31:0] r;
        int n_raised;
        int n_flush;
        int n;

        vecs[0]  = '{1'b0, 12'h305, 32'h0,         32'h0000_0100, "mtvec_rst"};
        vecs[1]  = '{1'b0, 12'h341, 32'h0,         32'h0,         "mepc_rst"};
        vecs[2]  = '{1'b0, 12'h342, 32'h0,         32'h0,         "mcause_rst"};
        vecs[3]  = '{1'b0, 12'h300, 32'h0,         32'h0,         "mstatus_rst"};
        vecs[4]  = '{1'b0, 12'h304, 32'h0,         32'h0,         "mie_rst"};
        vecs[5]  = '{1'b1, 12'h340, 32'hCAFE_BABE, 32'hCAFE_BABE, "mscratch_wr"};
        vecs[6]  = '{1'b1, 12'h341, 32'h1234_5677, 32'h1234_5674, "mepc_wr_align"};
        vecs[7]  = '{1'b1, 12'h305, 32'h0000_0203, MTVEC_W203,    "mtvec_wr_mask"};
        vecs[8]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088, "mstatus_wr_mask"};
        vecs[9]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 32'h0000_0800, "mie_wr_mask"};
        vecs[10] = '{1'b1, 12'h344, 32'hFFFF_FFFF, 32'h0,         "mip_readonly"};
        vecs[11] = '{1'b1, 12'h7C0, 32'hFFFF_FFFF, 32'h0,         "unmapped"};
        vecs[12] = '{1'b1, 12'h342, 32'h8000_000B, 32'h8000_000B, "mcause_wr"};
        vecs[13] = '{1'b1, 12'h343, 32'h0000_DEAD, 32'h0000_DEAD, "mtval_wr"};
        vecs[14] = '{1'b1, 12'h300, 32'h0,         32'h0,         "mstatus_clr"};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_e_raised", 32'(e_raised), 32'd0);
        chk("rst_trap_busy", 32'(trap_busy), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_addr", e_handling_addr, 32'd0);

        // ---------------- CSR table ----------------
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            chk(vecs[i].name, r, vecs[i].exp);
        end

        // mip mirrors ext_irq; with MIE=0 (MEIE=1) no trap is taken
        ext_irq = 1'b1;
        rd(12'h344, r);
        chk("mip_ext_irq", r, 32'h0000_0800);
        step();
        chk("irq_masked_no_raise", 32'(e_raised), 32'd0);
        ext_irq = 1'b0;

        // ---------------- exception + concurrent CSR write ----------------
        do_reset();
        exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
        csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55;
        step();
        exc_valid = 1'b0; csr_we = 1'b0;
        chk("exc_e_raised", 32'(e_raised), 32'd1);
        chk("exc_addr", e_handling_addr, 32'h100);
        chk("exc_busy", 32'(trap_busy), 32'd1);
        rd(12'h341, r); chk("exc_mepc", r, 32'h40);
        rd(12'h342, r); chk("exc_mcause_hw_wins", r, 32'd2);
        rd(12'h343, r); chk("exc_mtval", r, 32'hDEAD);
        n_raised = 0; n_flush = 0; n = 0;
        while ((flush || e_raised) && n < 30) begin
            if (e_raised) n_raised++;
            if (flush) n_flush++;
            step();
            n++;
        end
        chk("exc_raised_cycles", 32'(n_raised), 32'd1);
        chk("exc_flush_cycles", 32'(n_flush), 32'd3);
        chk("exc_busy_end", 32'(trap_busy), 32'd0);

        // ---------------- redirect held behind jump ----------------
        exc_valid = 1'b1; exc_code = 4'd4; exc_pc = 32'h60; exc_tval = 32'h0;
        step();
        exc_valid = 1'b0;
        n = 0;
        while (e_raised && n < 20) begin
            n++;
            if (e_handling_addr !== 32'h100) chk("jump_addr_stable", e_handling_addr, 32'h100);
            jump = (n <= 3);
            step();
        end
        jump = 1'b0;
        chk("jump_raised_cycles", 32'(n), 32'd4);
        chk("jump_then_drain_flush", 32'(flush), 32'd1);
        wait_run("jump_drain_end");

        // ---------------- interrupt then mret ----------------
        do_reset();
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        ext_irq = 1'b1; irq_pc = 32'h80;
        step();
        ext_irq = 1'b0;
        chk("irq_e_raised", 32'(e_raised), 32'd1);
        chk("irq_addr", e_handling_addr, 32'h100);
        rd(12'h342, r); chk("irq_mcause", r, 32'h8000_000B);
        rd(12'h341, r); chk("irq_mepc", r, 32'h80);
        rd(12'h343, r); chk("irq_mtval", r, 32'h0);
        rd(12'h300, r); chk("irq_mstatus", r, 32'h80);
        wait_run("irq_drain_end");
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("mret_e_raised", 32'(e_raised), 32'd1);
        chk("mret_addr", e_handling_addr, 32'h80);
        rd(12'h300, r); chk("mret_mstatus", r, 32'h88);
        wait_run("mret_drain_end");

        // ---------------- exception beats interrupt; DRAIN ignores events ----------------
        exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h44; exc_tval = 32'h11;
        ext_irq = 1'b1; irq_pc = 32'h90;
        step();
        exc_valid = 1'b0; ext_irq = 1'b0;
        rd(12'h342, r); chk("simul_mcause", r, 32'd5);
        rd(12'h341, r); chk("simul_mepc", r, 32'h44);
        step();
        chk("drain_state_flush", 32'(flush), 32'd1);
        exc_valid = 1'b1; exc_code = 4'd7; mret = 1'b1;
        wait_run("drain_ignore_end");
        exc_valid = 1'b0; mret = 1'b0;
        step();
        chk("drain_ignore_raised", 32'(e_raised), 32'd0);
        rd(12'h342, r); chk("drain_ignore_mcause", r, 32'd5);

        // ---------------- reset aborts REDIRECT ----------------
        exc_valid = 1'b1; exc_code = 4'd1; exc_pc = 32'hA0;
        step();
        exc_valid = 1'b0;
        chk("abort_pre_raised", 32'(e_raised), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_e_raised", 32'(e_raised), 32'd0);
        chk("abort_flush", 32'(flush), 32'd0);
        chk("abort_busy", 32'(trap_busy), 32'd0);
        rd(12'h341, r); chk("abort_mepc", r, 32'd0);
        rd(12'h300, r); chk("abort_mstatus", r, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ---------------- vectored mtvec ----------------
        wr(12'h305, 32'h201);
        rd(12'h305, r); chk("vec_mtvec_rd", r, MTVEC_R201);
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        ext_irq = 1'b1; irq_pc = 32'hB0;
        step();
        ext_irq = 1'b0;
        chk("vec_irq_addr", e_handling_addr, IRQ_VEC_TGT);
        wait_run("vec_irq_end");
        exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'hC0;
        step();
        exc_valid = 1'b0;
        chk("vec_exc_addr", e_handling_addr, 32'h200);
        wait_run("vec_exc_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap unit for the rv32i core; the source of the `e_raised` / `e_handling_addr` redirect consumed by the fetch next-PC selector.
- Latches exceptions, external interrupts and `mret` from the pipeline, owns the trap CSRs, and issues one redirect per event.
- Holds the redirect until the fetch selector can take it (a branch `jump` outranks it there), then drains the pipeline before accepting new events.

Parameters:
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset.
- DRAIN_CYCLES, 2, cycles in DRAIN after the redirect is accepted (legal range 1..15).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- exc_valid  input  1  synchronous exception from the pipeline this cycle
- exc_code  input  4  exception cause code (mcause[3:0], bit 31 = 0)
- exc_pc  input  32  PC of the faulting instruction
- exc_tval  input  32  trap value (bad address / instruction)
- ext_irq  input  1  level-sensitive machine external interrupt
- irq_pc  input  32  PC to resume at after the interrupt
- mret  input  1  mret retiring this cycle
- jump  input  1  branch/jump redirect into the fetch selector this cycle
- csr_we  input  1  CSR write strobe
- csr_addr  input  12  CSR address
- csr_wdata  input  32  CSR write data
- csr_rdata  output  32  CSR read data, combinational on csr_addr
- e_raised  output  1  redirect request to the fetch selector
- e_handling_addr  output  32  redirect target
- flush  output  1  squash IF/ID/EX contents
- trap_busy  output  1  high outside RUN

Behaviour:
- Reset (async, rst_n=0):
  - state = RUN; e_raised = 0; flush = 0; trap_busy = 0; e_handling_addr = 0.
  - mtvec = RESET_MTVEC; mepc = 0; mcause = 0; mtval = 0; mscratch = 0.
  - mstatus.MIE = 0; mstatus.MPIE = 0; mie.MEIE = 0.
- CSRs:
  - mstatus 0x300: bits 3 (MIE) and 7 (MPIE) only.
  - mie 0x304: bit 11 (MEIE) only.
  - mtvec 0x305: write forces bit 1 = 0.
  - mscratch 0x340.
  - mepc 0x341: write forces bits [1:0] = 0.
  - mcause 0x342; mtval 0x343.
  - mip 0x344: read-only, bit 11 = ext_irq.
  - Unmapped addresses read 0; writes to them are ignored.
- Event priority, sampled in RUN only: exc_valid > (ext_irq & MIE & MEIE) > mret.
  - Lower-priority simultaneous events are dropped; the pipeline re-presents them.
  - In all other states exc_valid, ext_irq and mret are ignored.
- Trap entry, on the RUN clock edge, with next state REDIRECT:
  - mepc = exc_pc or irq_pc, [1:0] cleared.
  - mcause = {0, 27'b0, exc_code} for an exception; 32'h8000_000B for the interrupt.
  - mtval = exc_tval for an exception; 0 for the interrupt.
  - MPIE = MIE; MIE = 0.
  - e_handling_addr = {mtvec[31:2], 2'b00}.
- mret accepted, with next state REDIRECT:
  - e_handling_addr = mepc; MIE = MPIE; MPIE = 1.
- A CSR write in the same cycle as a trap or mret update is discarded for the CSRs that the hardware updates.
- States:
  - RUN: idle; takes events as above.
  - REDIRECT: e_raised = 1, flush = 1; e_handling_addr stable. Stay while jump = 1, since the fetch selector gives jump priority. On the first cycle with jump = 0 the redirect is taken: go to DRAIN and load the counter with DRAIN_CYCLES-1.
  - DRAIN: e_raised = 0, flush = 1; counter decrements each cycle; return to RUN when counter = 0. Total DRAIN length = DRAIN_CYCLES.
- Outputs are registered.
  - Latency from the event cycle to e_raised is 1 cycle.
  - e_raised is high for at least 1 cycle.
- Reset asserted in REDIRECT or DRAIN aborts immediately to the reset values; no partial CSR state is retained beyond reset values.

Optional Feature:
- Macro: MTVEC_VECTORED_EN.
- Defined:
  - mtvec[1:0] = 01 selects vectored mode.
  - Interrupts redirect to {mtvec[31:2],2'b00} + 4*cause, i.e. base + 0x2C for the external interrupt.
  - Exceptions still go to the base.
  - mtvec bit 0 is writable.
- Undefined:
  - mtvec[1:0] are forced to 00 on write.
  - All traps go to the base.

Test Plan:
- Reset: rst_n low, then high -> mtvec reads 0x100; e_raised = 0; trap_busy = 0.
- Exception: exc_valid = 1, code = 2, exc_pc = 0x40, tval = 0xDEAD -> next cycle e_raised = 1, e_handling_addr = 0x100; mepc = 0x40, mcause = 2, mtval = 0xDEAD; flush for 1 + DRAIN_CYCLES cycles.
- Redirect held behind jump: trap raised while jump = 1 for 3 cycles -> e_raised stays 1 for 4 cycles, address unchanged; DRAIN starts after the jump = 0 cycle.
- Interrupt, then mret:
  - Set MIE, MEIE; ext_irq = 1, irq_pc = 0x80 -> mcause = 0x8000000B, mepc = 0x80, MIE = 0.
  - Then mret -> e_handling_addr = 0x80, MIE = 1.
- Simultaneous exception and interrupt in RUN -> exception taken (mcause = code); events during DRAIN are ignored.
- With MTVEC_VECTORED_EN: write mtvec = 0x201, raise the interrupt -> e_handling_addr = 0x22C; an exception -> 0x200.
